// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
//   Constants shared by the ALU-sharing arbiter slice: ALU operation
//   encodings, the operation-select width and the requester indices used
//   on the tagged response bus.
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam int SEL_W = 3;

  localparam logic [SEL_W-1:0] ALU_ADD = 3'b000;
  localparam logic [SEL_W-1:0] ALU_SUB = 3'b001;
  localparam logic [SEL_W-1:0] ALU_AND = 3'b010;
  localparam logic [SEL_W-1:0] ALU_OR  = 3'b011;
  localparam logic [SEL_W-1:0] ALU_SLT = 3'b101;

  localparam logic REQ_EXEC = 1'b0;  // main execute path
  localparam logic REQ_BR   = 1'b1;  // branch/address unit

endpackage

// File: rtl/alu.sv
// ---------------------------------------------------------------------------
// alu
//   Shared combinational ALU datapath.
//   Ports:
//     sel     in   SEL_W   operation select (alu_pkg ALU_* codes)
//     a, b    in   WIDTH   operands
//     result  out  WIDTH   operation result; unused codes produce 0
// ---------------------------------------------------------------------------
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [SEL_W-1:0] sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result
);

  always_comb begin
    result = '0;
    case (sel)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      // unsigned compare, single-bit result zero-extended
      ALU_SLT: result = {{(WIDTH-1){1'b0}}, (a < b)};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_share_arbiter_rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
//   Two-way request arbiter. Default build is round-robin: on contention
//   the requester that did not win last time is granted. last_grant
//   resets to REQ_BR so requester 0 wins the first contested cycle.
//   Optional macro ALU_SHARE_FIXED_PRIO_EN: requester 0 always wins on
//   contention and no last_grant state exists (no clock port either).
//   Ports:
//     clk              in   clock (round-robin build only)
//     rst              in   synchronous active-high reset; blocks grants
//     valid0, valid1   in   request valids
//     grant0, grant1   out  one-hot-or-zero grant, combinational
// ---------------------------------------------------------------------------
module rr_arb2
  import alu_pkg::*;
(
`ifndef ALU_SHARE_FIXED_PRIO_EN
  input  logic clk,
`endif
  input  logic rst,
  input  logic valid0,
  input  logic valid1,
  output logic grant0,
  output logic grant1
);

`ifdef ALU_SHARE_FIXED_PRIO_EN

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst) begin
      grant0 = valid0;
      grant1 = valid1 && !valid0;
    end
  end

`else

  logic last_grant;

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst) begin
      if (valid0 && valid1) begin
        grant0 = (last_grant == REQ_BR);
        grant1 = (last_grant == REQ_EXEC);
      end else begin
        grant0 = valid0;
        grant1 = valid1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= REQ_BR;
    end else if (grant0) begin
      last_grant <= REQ_EXEC;
    end else if (grant1) begin
      last_grant <= REQ_BR;
    end
  end

`endif

endmodule

// File: rtl/alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// alu_share_arbiter
//   Shares one combinational ALU between the execute path (requester 0)
//   and the branch/address unit (requester 1). At most one operation is
//   accepted per cycle; the result and zero flag are registered onto a
//   single tagged response bus one cycle after acceptance.
//   Optional macro ALU_SHARE_FIXED_PRIO_EN: fixed priority to requester 0
//   instead of round-robin (see rr_arb2).
//   Ports:
//     clk, rst                      clock, synchronous active-high reset
//     reqN_valid / reqN_ready       per-requester handshake (ready = grant)
//     reqN_sel, reqN_a, reqN_b      per-requester operation and operands
//     resp_valid                    one-cycle pulse per accepted op
//     resp_id                       owner of the response
//     resp_result, resp_zero        registered ALU result and zero flag;
//                                   held when no op was accepted
// ---------------------------------------------------------------------------
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [SEL_W-1:0] req0_sel,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [SEL_W-1:0] req1_sel,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             resp_valid,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_result,
  output logic             resp_zero
);

  logic             grant0;
  logic             grant1;
  logic             grant_any;
  logic [SEL_W-1:0] op_sel;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] alu_result;

  rr_arb2 u_arb (
`ifndef ALU_SHARE_FIXED_PRIO_EN
    .clk    (clk),
`endif
    .rst    (rst),
    .valid0 (req0_valid),
    .valid1 (req1_valid),
    .grant0 (grant0),
    .grant1 (grant1)
  );

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign grant_any  = grant0 | grant1;

  // grants are one-hot-or-zero, so grant1 alone picks the operand source
  assign op_sel = grant1 ? req1_sel : req0_sel;
  assign op_a   = grant1 ? req1_a   : req0_a;
  assign op_b   = grant1 ? req1_b   : req0_b;

  alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .sel    (op_sel),
    .a      (op_a),
    .b      (op_b),
    .result (alu_result)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid  <= 1'b0;
      resp_id     <= REQ_EXEC;
      resp_result <= '0;
      resp_zero   <= 1'b0;
    end else begin
      resp_valid <= grant_any;
      if (grant_any) begin
        resp_id     <= grant1 ? REQ_BR : REQ_EXEC;
        resp_result <= alu_result;
        resp_zero   <= (alu_result == '0);
      end
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;

  logic        clk;
  logic        rst;
  logic        req0_valid;
  logic        req0_ready;
  logic [2:0]  req0_sel;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic        req1_valid;
  logic        req1_ready;
  logic [2:0]  req1_sel;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  logic        resp_valid;
  logic        resp_id;
  logic [31:0] resp_result;
  logic        resp_zero;

  int checks;
  int errors;

  alu_share_arbiter #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_sel    (req0_sel),
    .req0_a      (req0_a),
    .req0_b      (req0_b),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_sel    (req1_sel),
    .req1_a      (req1_a),
    .req1_b      (req1_b),
    .resp_valid  (resp_valid),
    .resp_id     (resp_id),
    .resp_result (resp_result),
    .resp_zero   (resp_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req0_valid = 1'b1; req0_sel = 3'b000; req0_a = 32'd1; req0_b = 32'd1;
    req1_valid = 1'b1; req1_sel = 3'b000; req1_a = 32'd2; req1_b = 32'd2;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        errors++;
        $display("FAIL reset_ready: got %b%b expected 00", req0_ready, req1_ready);
      end
      step();
      checks++;
      if (resp_valid !== 1'b0 || resp_result !== 32'd0 || resp_zero !== 1'b0 || resp_id !== 1'b0) begin
        errors++;
        $display("FAIL reset_resp: got v=%b id=%b r=%h z=%b expected 0 0 0 0",
                 resp_valid, resp_id, resp_result, resp_zero);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_first_grant: got %b%b expected 10", req0_ready, req1_ready);
    end
    step();
    checks++;
    if (resp_valid !== 1'b1 || resp_id !== 1'b0 || resp_result !== 32'd2) begin
      errors++;
      $display("FAIL reset_first_resp: got v=%b id=%b r=%h expected 1 0 00000002",
               resp_valid, resp_id, resp_result);
    end
    idle_inputs();
    step();
  endtask

  task automatic test_single();
    req1_valid = 1'b1; req1_sel = 3'b000; req1_a = 32'd5; req1_b = 32'd7;
    @(negedge clk);
    checks++;
    if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
      errors++;
      $display("FAIL single_ready: got r0=%b r1=%b expected 0 1", req0_ready, req1_ready);
    end
    step();
    idle_inputs();
    checks++;
    if (resp_valid !== 1'b1 || resp_id !== 1'b1 || resp_result !== 32'd12 || resp_zero !== 1'b0) begin
      errors++;
      $display("FAIL single_resp: got v=%b id=%b r=%h z=%b expected 1 1 0000000c 0",
               resp_valid, resp_id, resp_result, resp_zero);
    end
  endtask

  task automatic test_contention();
    logic exp_id;
    req0_valid = 1'b1; req0_sel = 3'b001; req0_a = 32'd9;    req0_b = 32'd9;
    req1_valid = 1'b1; req1_sel = 3'b011; req1_a = 32'hF0;   req1_b = 32'h0F;
    for (int i = 0; i < 4; i++) begin
`ifdef ALU_SHARE_FIXED_PRIO_EN
      exp_id = 1'b0;
`else
      exp_id = (i % 2 == 1);
`endif
      @(negedge clk);
      checks++;
      if (req0_ready !== !exp_id || req1_ready !== exp_id) begin
        errors++;
        $display("FAIL contention_grant[%0d]: got r0=%b r1=%b expected r1=%b", i,
                 req0_ready, req1_ready, exp_id);
      end
      step();
      checks++;
      if (resp_valid !== 1'b1 || resp_id !== exp_id ||
          resp_result !== (exp_id ? 32'hFF : 32'h0) || resp_zero !== !exp_id) begin
        errors++;
        $display("FAIL contention_resp[%0d]: got v=%b id=%b r=%h z=%b expected id=%b", i,
                 resp_valid, resp_id, resp_result, resp_zero, exp_id);
      end
    end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    req0_valid = 1'b1; req0_sel = 3'b000; req0_a = 32'hFFFF_FFFF; req0_b = 32'd1;
    step();
    req0_sel = 3'b101; req0_a = 32'd3; req0_b = 32'd4;
    checks++;
    if (resp_valid !== 1'b1 || resp_result !== 32'd0 || resp_zero !== 1'b1) begin
      errors++;
      $display("FAIL b2b_add_wrap: got v=%b r=%h z=%b expected 1 00000000 1",
               resp_valid, resp_result, resp_zero);
    end
    step();
    idle_inputs();
    checks++;
    if (resp_valid !== 1'b1 || resp_result !== 32'd1 || resp_zero !== 1'b0) begin
      errors++;
      $display("FAIL b2b_slt: got v=%b r=%h z=%b expected 1 00000001 0",
               resp_valid, resp_result, resp_zero);
    end
    step();
    checks++;
    if (resp_valid !== 1'b0 || resp_result !== 32'd1 || resp_zero !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle_hold: got v=%b r=%h z=%b expected 0 00000001 0",
               resp_valid, resp_result, resp_zero);
    end
  endtask

  task automatic test_alu_ops();
    logic [2:0]  t_sel [8];
    logic [31:0] t_a   [8];
    logic [31:0] t_b   [8];
    logic [31:0] t_exp [8];
    t_sel[0] = 3'b111; t_a[0] = 32'd1;          t_b[0] = 32'd2;          t_exp[0] = 32'd0;
    t_sel[1] = 3'b100; t_a[1] = 32'd6;          t_b[1] = 32'd9;          t_exp[1] = 32'd0;
    t_sel[2] = 3'b110; t_a[2] = 32'd6;          t_b[2] = 32'd9;          t_exp[2] = 32'd0;
    t_sel[3] = 3'b010; t_a[3] = 32'h0000_F0F0;  t_b[3] = 32'h0000_0FF0;  t_exp[3] = 32'h0000_00F0;
    t_sel[4] = 3'b001; t_a[4] = 32'd0;          t_b[4] = 32'd1;          t_exp[4] = 32'hFFFF_FFFF;
    t_sel[5] = 3'b101; t_a[5] = 32'hFFFF_FFFF;  t_b[5] = 32'd1;          t_exp[5] = 32'd0;
    t_sel[6] = 3'b101; t_a[6] = 32'd1;          t_b[6] = 32'h8000_0000;  t_exp[6] = 32'd1;
    t_sel[7] = 3'b011; t_a[7] = 32'h1234_0000;  t_b[7] = 32'h0000_5678;  t_exp[7] = 32'h1234_5678;
    for (int i = 0; i < 8; i++) begin
      req1_valid = 1'b1; req1_sel = t_sel[i]; req1_a = t_a[i]; req1_b = t_b[i];
      step();
      idle_inputs();
      checks++;
      if (resp_valid !== 1'b1 || resp_id !== 1'b1 || resp_result !== t_exp[i] ||
          resp_zero !== (t_exp[i] == 32'd0)) begin
        errors++;
        $display("FAIL alu_op[%0d] sel=%b: got v=%b id=%b r=%h z=%b expected r=%h", i, t_sel[i],
                 resp_valid, resp_id, resp_result, resp_zero, t_exp[i]);
      end
      step();
      checks++;
      if (resp_valid !== 1'b0 || resp_result !== t_exp[i]) begin
        errors++;
        $display("FAIL alu_idle_hold[%0d]: got v=%b r=%h expected 0 %h", i,
                 resp_valid, resp_result, t_exp[i]);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic exp_id;
    // leave last_grant at requester 0 so the reset value is observable
    req0_valid = 1'b1; req0_sel = 3'b000; req0_a = 32'd10; req0_b = 32'd20;
    step();
    checks++;
    if (resp_valid !== 1'b1 || resp_id !== 1'b0 || resp_result !== 32'd30) begin
      errors++;
      $display("FAIL midrst_pre: got v=%b id=%b r=%h expected 1 0 0000001e",
               resp_valid, resp_id, resp_result);
    end
    req0_a = 32'd2; req0_b = 32'd3;
    @(negedge clk);
    checks++;
    if (req0_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst_ready_before: got %b expected 1", req0_ready);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL midrst_ready_forced: got %b%b expected 00", req0_ready, req1_ready);
    end
    step();
    checks++;
    if (resp_valid !== 1'b0 || resp_result !== 32'd0) begin
      errors++;
      $display("FAIL midrst_discard: got v=%b r=%h expected 0 00000000", resp_valid, resp_result);
    end
    req1_valid = 1'b1; req1_sel = 3'b000; req1_a = 32'd1; req1_b = 32'd1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
`ifdef ALU_SHARE_FIXED_PRIO_EN
      exp_id = 1'b0;
`else
      exp_id = (i % 2 == 1);
`endif
      @(negedge clk);
      checks++;
      if (req0_ready !== !exp_id || req1_ready !== exp_id) begin
        errors++;
        $display("FAIL midrst_grant[%0d]: got r0=%b r1=%b expected r1=%b", i,
                 req0_ready, req1_ready, exp_id);
      end
      step();
      checks++;
      if (resp_valid !== 1'b1 || resp_id !== exp_id ||
          resp_result !== (exp_id ? 32'd2 : 32'd5)) begin
        errors++;
        $display("FAIL midrst_resp[%0d]: got v=%b id=%b r=%h expected id=%b", i,
                 resp_valid, resp_id, resp_result, exp_id);
      end
    end
    idle_inputs();
    step();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    req0_valid = 1'b0; req0_sel = 3'b000; req0_a = 32'd0; req0_b = 32'd0;
    req1_valid = 1'b0; req1_sel = 3'b000; req1_a = 32'd0; req1_b = 32'd0;
    test_reset();
    test_single();
    test_contention();
    test_back_to_back();
    test_alu_ops();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
